// File: rtl/sample_packer.sv
// Serial-to-parallel sample packer: gathers BUS_WIDTH samples into one group,
// drops partial groups cut short by i_last, and keeps a saturating drop count.
module sample_packer #(
    parameter int BUS_WIDTH  = 4,
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic [DATA_WIDTH-1:0]        i_data,
    input  logic                         i_last,
    input  logic                         i_clr,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data [0:BUS_WIDTH-1],
    output logic                         o_drop,
    output logic [CNT_WIDTH-1:0]         o_drop_count,
    output logic [$clog2(BUS_WIDTH):0]   o_fill
);

    localparam int IDX_W  = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
    localparam int FILL_W = $clog2(BUS_WIDTH) + 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BUS_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    generate
        if ((BUS_WIDTH < 1) || ((BUS_WIDTH & (BUS_WIDTH - 1)) != 0)) begin : g_bad_width
            $fatal(1, "sample_packer: BUS_WIDTH must be a power of 2");
        end
    endgenerate

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] stage_q [0:BUS_WIDTH-1];
    logic [DATA_WIDTH-1:0] stage_d [0:BUS_WIDTH-1];
    logic [DATA_WIDTH-1:0] data_q  [0:BUS_WIDTH-1];
    logic [DATA_WIDTH-1:0] data_d  [0:BUS_WIDTH-1];
    logic                  valid_q, valid_d;
    logic                  drop_q, drop_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    always_comb begin
        idx_d   = idx_q;
        stage_d = stage_q;
        data_d  = data_q;
        valid_d = 1'b0;
        drop_d  = 1'b0;
        cnt_d   = cnt_q;
        // Clear wins over an incoming sample; the sample is simply ignored.
        if (i_clr) begin
            idx_d = '0;
            cnt_d = '0;
        end else if (i_valid) begin
            stage_d[idx_q] = i_data;
            if (idx_q == LAST_IDX) begin
                data_d  = stage_d;
                valid_d = 1'b1;
                idx_d   = '0;
            end else if (i_last) begin
                idx_d  = '0;
                drop_d = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            stage_q <= '{default: '0};
            data_q  <= '{default: '0};
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            stage_q <= stage_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_drop       = drop_q;
    assign o_drop_count = cnt_q;
    assign o_fill       = FILL_W'(idx_q);

endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 4: samples per output group; a value that is not a power of 2 SHALL raise $fatal at elaboration.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 6: bits per sample.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 8: width of the drop counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port i_valid, input, 1 bit: i_data and i_last are valid this cycle.
REQ-007 The block SHALL have port i_data, input, DATA_WIDTH bits: serial sample.
REQ-008 The block SHALL have port i_last, input, 1 bit: the sample is the final one of a frame.
REQ-009 The block SHALL have port i_clr, input, 1 bit: synchronous discard of the partial group and clear of the drop counter.
REQ-010 The block SHALL have port o_valid, output, 1 bit: one-cycle pulse marking a new full group on o_data.
REQ-011 The block SHALL have port o_data, output, unpacked array [0:BUS_WIDTH-1] of DATA_WIDTH bits: the packed group, sized to drive the mean stage's i_data directly.
REQ-012 The block SHALL have port o_drop, output, 1 bit: one-cycle pulse marking a discarded partial group.
REQ-013 The block SHALL have port o_drop_count, output, CNT_WIDTH bits: saturating count of discarded groups.
REQ-014 The block SHALL have port o_fill, output, $clog2(BUS_WIDTH)+1 bits: number of samples held in the partial group.

Function
REQ-015 The block SHALL keep a slot index (0..BUS_WIDTH-1) and a staging buffer separate from the o_data register.
REQ-016 On an edge with i_valid=1 and i_clr=0, the sample SHALL be written to staging[index]; the first sample of a group SHALL go to slot 0.
REQ-017 When the index is BUS_WIDTH-1 at an accepting edge, o_data SHALL load the complete group including that sample, o_valid SHALL be 1 for exactly the following cycle, and the index SHALL return to 0.
REQ-018 Latency SHALL be 1 cycle: o_valid asserts in the cycle after the edge that accepts the last sample of a group.
REQ-019 The block SHALL accept one sample per cycle with no stalls; continuous input SHALL produce an o_valid pulse every BUS_WIDTH cycles.
REQ-020 o_data SHALL hold its value between groups; partial writes SHALL never be visible on o_data.
REQ-021 An accepted sample with i_last=1 at an index below BUS_WIDTH-1 SHALL discard the partial group, reset the index to 0, pulse o_drop for one cycle, and increment o_drop_count; o_data and o_valid SHALL not change.
REQ-022 i_last=1 at index BUS_WIDTH-1 SHALL be treated as a normal full group (REQ-017) with no drop.
REQ-023 i_last SHALL be ignored when i_valid=0.
REQ-024 o_drop_count SHALL saturate at 2**CNT_WIDTH-1 and not wrap.
REQ-025 i_clr=1 SHALL take priority over i_valid: the sample is ignored, the index is set to 0, o_drop_count is set to 0, no o_drop pulse is produced, and o_data is unchanged.
REQ-026 o_fill SHALL equal the current index, i.e. the number of samples staged toward the next group.

Reset
REQ-027 Asserting rst SHALL immediately set o_valid=0, o_drop=0, o_drop_count=0, o_fill=0, the index to 0, and all o_data and staging words to 0.
REQ-028 Reset asserted in the middle of a group SHALL discard that group without an o_drop pulse; the first sample accepted after release SHALL go to slot 0.

Verification (BUS_WIDTH=4, DATA_WIDTH=6, CNT_WIDTH=8)
REQ-029 The bench SHALL drive samples 1,2,3,4 on consecutive cycles and check that o_valid pulses once, one cycle after the 4th sample, with o_data={1,2,3,4}, and that the mean stage output equals 2.
REQ-030 The bench SHALL drive 8 back-to-back samples 63 and check two o_valid pulses 4 cycles apart, each with o_data={63,63,63,63}.
REQ-031 The bench SHALL drive samples 5,6 with i_last on 6 and check o_drop for one cycle, o_drop_count=1, no o_valid, and o_data unchanged; the next 4 samples 7,8,9,10 SHALL produce o_data={7,8,9,10}.
REQ-032 The bench SHALL drive samples with gaps (valid pattern 1,0,1,0,0,1,1) and check a single o_valid after the 4th accepted sample, and that o_fill follows 1,1,2,2,2,3,0.
REQ-033 The bench SHALL force 300 drop events and check that o_drop_count stops at 255; then i_clr with i_valid=1 SHALL give o_drop_count=0, o_fill=0, and the sample SHALL be ignored.
REQ-034 The bench SHALL assert rst asynchronously (between clock edges) after 2 samples and check that all outputs are 0 immediately; after release, samples 1,2,3,4 SHALL produce o_data={1,2,3,4}.
